// File: rtl/dr_sync_pkg.sv
// Shared types and constants for the dual-rail to synchronous receiver.
// Codewords are packed as {rail1, rail0}.
package dr_sync_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACKED = 1'b1
    } dr_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 3;

    localparam logic [1:0] DR_NEUTRAL = 2'b00;
    localparam logic [1:0] DR_D0      = 2'b01;
    localparam logic [1:0] DR_D1      = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    // True for a codeword that carries exactly one data value.
    function automatic logic dr_is_token(input logic [1:0] cw);
        return (cw == DR_D0) || (cw == DR_D1);
    endfunction

endpackage

// File: rtl/dr_sync_rx_if.sv
// Dual-rail input channel plus clocked valid/ready output stream.
// The receiver uses the slave modport; the sender/consumer side uses master.
interface dr_sync_rx_if;
    logic a_d0;
    logic a_d1;
    logic a_ack;
    logic z;
    logic z_valid;
    logic z_ready;
    logic err;

    modport slave (
        input  a_d0, a_d1, z_ready,
        output a_ack, z, z_valid, err
    );

    modport master (
        output a_d0, a_d1, z_ready,
        input  a_ack, z, z_valid, err
    );
endinterface

// File: rtl/dr_sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module dr_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic ck,
    input  logic rst_b,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge ck or negedge rst_b) begin
        if (!rst_b) begin
            r_sync <= {STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dr_sync_rx.sv
// Four-phase dual-rail receiver: synchronizes both rails, acknowledges each token
// into an inline FIFO and withholds acknowledge while full. Optional: DR_SYNC_RX_ERR_EN.
module dr_sync_rx
    import dr_sync_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         ck,
    input  logic         rst_b,
    dr_sync_rx_if.slave  bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT  = (AW+1)'(0);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic            w_s_d0;
    logic            w_s_d1;
    logic [1:0]      w_cw;
    dr_state_e       r_state;
    dr_state_e       w_state_nxt;
    logic            r_ack;
    logic            w_ack_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_last;

    dr_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_d0 (
        .ck   (ck),
        .rst_b(rst_b),
        .i_d  (bus.a_d0),
        .o_q  (w_s_d0)
    );

    dr_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_d1 (
        .ck   (ck),
        .rst_b(rst_b),
        .i_d  (bus.a_d1),
        .o_q  (w_s_d1)
    );

    assign w_cw   = {w_s_d1, w_s_d0};
    // Full check uses the registered count so a same-cycle pop frees a slot only next cycle.
    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = (r_count != ZERO_CNT) && bus.z_ready;

    // Next-state, acknowledge and push decode for the four-phase handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dr_is_token(w_cw) && !w_full) begin
                    w_push      = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACKED;
                end else begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACKED: begin
                if (w_cw == DR_NEUTRAL) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACKED;
                end
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake state and acknowledge register.
    always_ff @(posedge ck or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // Storage array; stale contents are harmless because pointers and count gate every read.
    always_ff @(posedge ck) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_s_d1;
        end
    end

    // FIFO pointers, occupancy and the last-popped value shown while empty.
    always_ff @(posedge ck or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= ZERO_CNT;
            r_last   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.a_ack   = r_ack;
    assign bus.z_valid = (r_count != ZERO_CNT);
    assign bus.z       = (r_count != ZERO_CNT) ? r_mem[r_rd_ptr] : r_last;

`ifdef DR_SYNC_RX_ERR_EN
    logic r_err;

    // Sticky flag for a both-rails-high codeword seen on the synchronized rails.
    always_ff @(posedge ck or negedge rst_b) begin
        if (!rst_b) begin
            r_err <= 1'b0;
        end else if (w_cw == DR_ILLEGAL) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_sync_rx.sv
// Scoreboard bench for dr_sync_rx: stimulus pushes expected tokens, a negedge monitor
// pops and compares on every z_valid && z_ready handshake.
module tb_dr_sync_rx;

    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic ck = 1'b0;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    logic exp_q [$];

    dr_sync_rx_if u_if ();

    dr_sync_rx #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .ck   (ck),
        .rst_b(rst_b),
        .bus  (u_if)
    );

    always #5 ck = ~ck;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic wait_ack(input logic v, input string name);
        for (int k = 0; k < 40 && u_if.a_ack !== v; k++) step(1);
        check(name, u_if.a_ack, v);
    endtask

    task automatic send(input logic v);
        exp_q.push_back(v);
        if (v) u_if.a_d1 = 1'b1;
        else   u_if.a_d0 = 1'b1;
        wait_ack(1'b1, "ack_rise");
        u_if.a_d0 = 1'b0;
        u_if.a_d1 = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && u_if.z_valid !== 1'b0; k++) step(1);
        check(name, u_if.z_valid, 1'b0);
        check({name, "_sb_empty"}, (exp_q.size() == 0), 1'b1);
    endtask

    // Monitor: every accepted output must match the oldest expected token.
    always @(negedge ck) begin
        logic e;
        if (rst_b === 1'b1 && u_if.z_valid === 1'b1 && u_if.z_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%0b required=none", u_if.z);
            end else begin
                e = exp_q.pop_front();
                if (u_if.z !== e) begin
                    errors++;
                    $display("FAIL pop_data actual=%0b required=%0b", u_if.z, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] pat;
        pat = 12'b1011_0010_1101;
        u_if.a_d0    = 1'b0;
        u_if.a_d1    = 1'b0;
        u_if.z_ready = 1'b0;
        rst_b        = 1'b0;

        // Reset held while rails toggle
        step(1);
        u_if.a_d1 = 1'b1;
        step(2);
        check("rst_ack", u_if.a_ack, 1'b0);
        check("rst_valid", u_if.z_valid, 1'b0);
        check("rst_err", u_if.err, 1'b0);
        check("rst_z", u_if.z, 1'b0);
        u_if.a_d1 = 1'b0;
        u_if.a_d0 = 1'b1;
        step(2);
        check("rst_ack_d0", u_if.a_ack, 1'b0);
        check("rst_valid_d0", u_if.z_valid, 1'b0);
        u_if.a_d0 = 1'b0;
        step(2);
        rst_b = 1'b1;
        step(4);
        check("post_rst_ack", u_if.a_ack, 1'b0);
        check("post_rst_valid", u_if.z_valid, 1'b0);
        check("post_rst_err", u_if.err, 1'b0);

        // Single token: ack and data appear at the SS-th edge after the first capture edge
        u_if.a_d1 = 1'b1;
        exp_q.push_back(1'b1);
        step(1);
        check("t1_e1_ack", u_if.a_ack, 1'b0);
        step(1);
        check("t1_e2_ack", u_if.a_ack, 1'b0);
        check("t1_e2_valid", u_if.z_valid, 1'b0);
        step(1);
        check("t1_e3_ack", u_if.a_ack, 1'b1);
        check("t1_e3_valid", u_if.z_valid, 1'b1);
        check("t1_e3_z", u_if.z, 1'b1);
        u_if.a_d1 = 1'b0;
        step(2);
        check("t1_fall_e2_ack", u_if.a_ack, 1'b1);
        step(1);
        check("t1_fall_e3_ack", u_if.a_ack, 1'b0);
        check("t1_no_dup_valid", u_if.z_valid, 1'b1);
        u_if.z_ready = 1'b1;
        step(1);
        check("t1_pop_valid", u_if.z_valid, 1'b0);
        check("t1_hold_z", u_if.z, 1'b1);
        step(2);
        check("empty_pop_valid", u_if.z_valid, 1'b0);
        check("empty_hold_z", u_if.z, 1'b1);
        u_if.z_ready = 1'b0;

        // Backpressure: four fill the FIFO, the fifth is held unacknowledged
        send(1'b0);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        check("bp_full_valid", u_if.z_valid, 1'b1);
        u_if.a_d1 = 1'b1;
        exp_q.push_back(1'b1);
        step(10);
        check("bp_hold_ack", u_if.a_ack, 1'b0);
        u_if.z_ready = 1'b1;
        wait_ack(1'b1, "bp_ack5");
        u_if.a_d1 = 1'b0;
        wait_ack(1'b0, "bp_ack5_fall");
        drain("bp_drain");
        u_if.z_ready = 1'b0;

        // Stream from full with steady ready, across several pointer wraps
        send(1'b1);
        send(1'b0);
        send(1'b0);
        send(1'b1);
        u_if.z_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(pat[i]);
        drain("stream_drain");
        u_if.z_ready = 1'b0;

        // Reset in the middle of a handshake with three entries stored
        send(1'b0);
        send(1'b1);
        u_if.a_d0 = 1'b1;
        wait_ack(1'b1, "mid_ack");
        check("mid_valid", u_if.z_valid, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_rst_ack_async", u_if.a_ack, 1'b0);
        check("mid_rst_valid_async", u_if.z_valid, 1'b0);
        exp_q.delete();
        u_if.a_d0 = 1'b0;
        step(3);
        rst_b = 1'b1;
        step(3);
        check("mid_post_valid", u_if.z_valid, 1'b0);
        check("mid_post_ack", u_if.a_ack, 1'b0);
        send(1'b1);
        u_if.z_ready = 1'b1;
        step(1);
        check("mid_count_zero", u_if.z_valid, 1'b0);
        u_if.z_ready = 1'b0;

        // Both rails high
        u_if.a_d0 = 1'b1;
        u_if.a_d1 = 1'b1;
        step(SS + 1);
`ifdef DR_SYNC_RX_ERR_EN
        check("ill_err", u_if.err, 1'b1);
`else
        check("ill_err_tied", u_if.err, 1'b0);
`endif
        check("ill_ack", u_if.a_ack, 1'b0);
        check("ill_valid", u_if.z_valid, 1'b0);
        u_if.a_d0 = 1'b0;
        u_if.a_d1 = 1'b0;
        step(4);
        send(1'b0);
        check("ill_then_d0_valid", u_if.z_valid, 1'b1);
        u_if.z_ready = 1'b1;
        step(1);
        check("ill_then_d0_pop", u_if.z_valid, 1'b0);
`ifdef DR_SYNC_RX_ERR_EN
        check("ill_err_sticky", u_if.err, 1'b1);
`else
        check("ill_err_still_0", u_if.err, 1'b0);
`endif
        u_if.z_ready = 1'b0;
        step(2);

        check("final_sb_empty", (exp_q.size() == 0), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
